// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline control logic.
package pipe_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  // A register index can only collide with a real producer; r0 is hard-wired zero.
  function automatic logic reg_match(input logic [REG_IDX_W-1:0] producer,
                                     input logic [REG_IDX_W-1:0] consumer);
    return (producer != {REG_IDX_W{1'b0}}) && (producer == consumer);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparison between the EX-stage load and the ID-stage sources.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic                 ex_mem_read_i,
  input  logic [REG_IDX_W-1:0] ex_write_reg_i,
  input  logic [REG_IDX_W-1:0] id_rs_i,
  input  logic [REG_IDX_W-1:0] id_rt_i,
  input  logic                 id_uses_rt_i,
  output logic                 lu_hazard_o
);

  // rt only matters when the ID instruction actually reads it as a source.
  always_comb begin
    lu_hazard_o = 1'b0;
    if (ex_mem_read_i) begin
      lu_hazard_o = reg_match(ex_write_reg_i, id_rs_i) |
                    (id_uses_rt_i & reg_match(ex_write_reg_i, id_rt_i));
    end else begin
      lu_hazard_o = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: drives capture, flush and bubble controls of the pipeline
// registers for load-use hazards, taken branches and data-memory waits with timeout.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rt,
  input  logic                 ex_MemRead,
  input  logic [REG_IDX_W-1:0] ex_writeReg,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 IFIDWrite,
  output logic                 IFIDFlush,
  output logic                 IDEXWrite,
  output logic                 IDEXBubble,
  output logic                 EXMEMWrite,
  output logic                 MEMWBBubble,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 mem_timeout
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                mem_timeout_q, mem_timeout_d;
  logic                memwait_s;
  logic                lu_hazard_s;

  assign memwait_s = mem_req & ~mem_ready;

  hazard_detect u_hazard_detect (
    .ex_mem_read_i  (ex_MemRead),
    .ex_write_reg_i (ex_writeReg),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_uses_rt_i   (id_uses_rt),
    .lu_hazard_o    (lu_hazard_s)
  );

  // Control outputs: priority ERROR > memory wait > load-use > taken branch.
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXWrite   = 1'b1;
    IDEXBubble  = 1'b0;
    EXMEMWrite  = 1'b1;
    MEMWBBubble = 1'b0;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (memwait_s) begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IDEXWrite   = 1'b0;
          EXMEMWrite  = 1'b0;
          MEMWBBubble = 1'b1;
        end else if (lu_hazard_s) begin
          // The branch is suppressed here and re-resolved once the load has moved on.
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
        end else if (branch_taken) begin
          IFIDFlush = 1'b1;
        end else begin
          IFIDFlush = 1'b0;
        end
      end
      default: begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEXWrite   = 1'b0;
        EXMEMWrite  = 1'b0;
        MEMWBBubble = 1'b1;
      end
    endcase
  end

  // Next state, wait counter, error flag and saturating stall counter.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d   = stall_cnt_q;
    case (state_q)
      RUN: begin
        if (memwait_s) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          wait_cnt_d = {WAIT_W{1'b0}};
        end
      end
      MEM_WAIT: begin
        if (!memwait_s) begin
          state_d    = RUN;
          wait_cnt_d = {WAIT_W{1'b0}};
        end else if (wait_cnt_q >= WAIT_MAX) begin
          state_d       = ERROR;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = ERROR;
      end
    endcase
    if (!PCWrite && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= {WAIT_W{1'b0}};
      stall_cnt_q   <= {CNT_W{1'b0}};
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall controller for the 5-stage pipeline. It decides each cycle whether the PC and the IF/ID, ID/EX and EX/MEM pipeline registers capture, hold or flush. It also decides whether MEM/WB receives a bubble. It covers load-use hazards, taken branches/jumps resolved in ID, and a multi-cycle data-memory wait with timeout. It sits beside the datapath and drives the write-enable, flush and bubble controls of the pipeline registers.

## Interface
Parameters:
- MEM_TIMEOUT, default 15: maximum consecutive memory-wait cycles before error.
- CNT_W, default 16: width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_MemRead  in  1  instruction in EX is a load.
- ex_writeReg  in  5  destination register of the EX instruction.
- branch_taken  in  1  taken branch or jump resolved in ID this cycle.
- mem_req  in  1  MEM stage holds an active load/store.
- mem_ready  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC captures its next value.
- IFIDWrite  out  1  IF/ID captures.
- IFIDFlush  out  1  IF/ID loads a NOP (instru = 0).
- IDEXWrite  out  1  ID/EX captures.
- IDEXBubble  out  1  ID/EX control fields are zeroed.
- EXMEMWrite  out  1  EX/MEM captures.
- MEMWBBubble  out  1  MEM/WB MemtoReg/RegWrite are forced to 0.
- stall_cnt  out  CNT_W  count of cycles with PCWrite = 0.
- mem_timeout  out  1  sticky memory-timeout error flag.

## Operation
- State machine states: RUN, MEM_WAIT, ERROR. Registered state: state, wait_cnt (log2(MEM_TIMEOUT)+1 bits), stall_cnt, mem_timeout.
- Control outputs are combinational from state and the current inputs.
- Default for all cycles: all Write = 1, all Flush/Bubble = 0.
- Conditions:
  - memwait = mem_req & ~mem_ready.
  - lu_hazard = ex_MemRead & (ex_writeReg != 0) & (ex_writeReg == id_rs | (id_uses_rt & ex_writeReg == id_rt)).
- Priority, highest first:
  1. ERROR: all Write = 0, MEMWBBubble = 1. Flushes are 0.
  2. memwait, in any non-ERROR state: PCWrite, IFIDWrite, IDEXWrite and EXMEMWrite = 0; MEMWBBubble = 1.
  3. lu_hazard: PCWrite = 0, IFIDWrite = 0, IDEXBubble = 1. IDEXWrite stays 1 so the bubble is captured. IFIDFlush = 0 even if branch_taken; the branch is re-evaluated next cycle.
  4. branch_taken: IFIDFlush = 1.
- Transitions:
  - RUN → MEM_WAIT when memwait; wait_cnt becomes 1.
  - MEM_WAIT stays while memwait and wait_cnt < MEM_TIMEOUT; wait_cnt increments.
  - MEM_WAIT → RUN when !memwait; wait_cnt clears.
  - MEM_WAIT → ERROR when memwait and wait_cnt == MEM_TIMEOUT; mem_timeout is set to 1.
  - ERROR exits only by reset.
- stall_cnt increments on every edge where PCWrite = 0, including ERROR cycles. It saturates at 2^CNT_W−1.
- Register 0 never creates a hazard.

## Timing
- Reset values: state = RUN, wait_cnt = 0, stall_cnt = 0, mem_timeout = 0. Combinational outputs then follow the RUN equations.
- Reset asserted mid-wait or in ERROR: return to RUN immediately, without waiting for a clock.
- Latency: zero cycles from input to control output. State, counters and the error flag update on the next rising edge.
- A load-use stall lasts exactly 1 cycle when no other event occurs.
- The MEM_WAIT exit cycle (mem_ready = 1) is a normal RUN-equation cycle and may itself raise lu_hazard.
- Simultaneous memwait and lu_hazard: memwait wins. The hazard is re-detected after the wait because ID and EX were held.
- Timeout: with mem_ready held low, ERROR is entered on edge MEM_TIMEOUT+1 counted from the first wait cycle.

## Structure
- Shared package `pipe_pkg`:
  - state enum {RUN, MEM_WAIT, ERROR};
  - NOP instruction constant 32'h0;
  - register-index width constant 5.
- One natural sub-module, `hazard_detect`: purely combinational lu_hazard comparison, reusable by a future forwarding unit.
- Everything else is flat.

## Test plan
- Load-use on rs: ex_MemRead=1, ex_writeReg=8, id_rs=8 → for one cycle PCWrite=0, IFIDWrite=0, IDEXBubble=1. Next cycle all defaults; stall_cnt=1.
- Register-0 and rt-unused cases:
  - ex_writeReg=0 with id_rs=0 → no stall.
  - ex_writeReg=9, id_rt=9, id_uses_rt=0 → no stall.
- Branch: branch_taken=1 with no hazard → IFIDFlush=1, PCWrite=1. Branch_taken=1 together with lu_hazard → IFIDFlush=0, stall asserted.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles then high → 3 cycles of all Write=0 and MEMWBBubble=1, then RUN; stall_cnt=3.
- Timeout: MEM_TIMEOUT=15, mem_ready held low → ERROR entered, mem_timeout=1 after 16 edges. Outputs stay frozen; rst_n low returns to RUN with counters 0.
- Reset during MEM_WAIT: after 2 wait cycles, pulse rst_n low between edges → state RUN and wait_cnt=0 immediately, before the next edge.
